ledmatrix_axi_regs: RTL and testbench

LEDMATRIX_AXI_REGS -- requirements
Module: ledmatrix_axi_regs

---
 rtl/ledmatrix_axi_regs.sv | 156 +++++++++++++++
 tb/tb_ledmatrix_axi_regs.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledmatrix_axi_regs.sv
// rtl/ledmatrix_axi_regs.sv - AXI4-Lite slave exposing four 32-bit LED matrix control registers
// AW and W are captured independently and paired at commit.
// Reads sample the register file before any same-edge write takes effect.
module ledmatrix_axi_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                        s_axi_awprot,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                        s_axi_arprot,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3,
   output logic [3:0]                        wr_pulse
);

   localparam int NB = C_S_AXI_DATA_WIDTH / 8;

   logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
   logic                          r_aw_held;
   logic [1:0]                    r_aw_idx;
   logic                          r_w_held;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
   logic [NB-1:0]                 r_wstrb;
   logic                          r_bvalid;
   logic                          r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [3:0]                    r_wr_pulse;

   logic                          w_awready;
   logic                          w_wready;
   logic                          w_arready;
   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic                          w_ar_hs;
   logic                          w_commit;
   logic [1:0]                    w_wr_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
   logic [NB-1:0]                 w_wr_strb;
   logic                          w_unused;

   // Protection bits and byte offset carry no meaning for this register window.
   assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Readies are gated by ARESETN so nothing is accepted while reset is held.
   assign w_awready = ARESETN & ~r_aw_held & ~r_bvalid;
   assign w_wready  = ARESETN & ~r_w_held & ~r_bvalid;
   assign w_arready = ARESETN & ~r_rvalid;

   assign w_aw_hs  = s_axi_awvalid & w_awready;
   assign w_w_hs   = s_axi_wvalid & w_wready;
   assign w_ar_hs  = s_axi_arvalid & w_arready;

   // Commit as soon as both halves are available, held or arriving this edge.
   assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
   assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axi_awaddr[3:2];
   assign w_wr_data = r_w_held  ? r_wdata  : s_axi_wdata;
   assign w_wr_strb = r_w_held  ? r_wstrb  : s_axi_wstrb;

   // Hold an early AW or W beat until its partner shows up; drop both at commit.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_aw_held <= 1'b0;
         r_aw_idx  <= 2'd0;
         r_w_held  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         if (w_aw_hs) r_aw_idx <= s_axi_awaddr[3:2];
         if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
            r_wstrb <= s_axi_wstrb;
         end
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end else begin
            if (w_aw_hs) r_aw_held <= 1'b1;
            if (w_w_hs)  r_w_held  <= 1'b1;
         end
      end
   end

   // Byte-masked register update; the strobe fires even when no byte is enabled.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
         r_wr_pulse <= 4'd0;
      end else begin
         r_wr_pulse <= w_commit ? (4'b0001 << w_wr_idx) : 4'b0000;
         if (w_commit) begin
            for (int b = 0; b < NB; b++) begin
               if (w_wr_strb[b]) r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
         end
      end
   end

   // Write response: raised at commit, held until the master takes it.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_bvalid <= 1'b0;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
      end else if (s_axi_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read path: capture the addressed register, hold data stable until rready.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= r_regs[s_axi_araddr[3:2]];
      end else if (r_rvalid && s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

   assign s_axi_awready = w_awready;
   assign s_axi_wready  = w_wready;
   assign s_axi_arready = w_arready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = 2'b00;
   assign reg0          = r_regs[0];
   assign reg1          = r_regs[1];
   assign reg2          = r_regs[2];
   assign reg3          = r_regs[3];
   assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_ledmatrix_axi_regs.sv
// tb/tb_ledmatrix_axi_regs.sv - directed self-checking bench for ledmatrix_axi_regs
module tb_ledmatrix_axi_regs;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [3:0]  s_axi_awaddr;
   logic [2:0]  s_axi_awprot;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [3:0]  s_axi_araddr;
   logic [2:0]  s_axi_arprot;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [31:0] reg0, reg1, reg2, reg3;
   logic [3:0]  wr_pulse;

   int n_cmp  = 0;
   int n_fail = 0;

   ledmatrix_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .wr_pulse(wr_pulse)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int lat, output logic [3:0] pulse, output logic [1:0] resp);
      int  n = 0;
      int  m = 0;
      bit  awd = 0, wd = 0, aa, ww;
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b1;
      while (!(awd && wd) && n < 20) begin
         aa = s_axi_awvalid && s_axi_awready;
         ww = s_axi_wvalid && s_axi_wready;
         tick(); n++;
         if (aa) begin s_axi_awvalid = 1'b0; awd = 1; end
         if (ww) begin s_axi_wvalid = 1'b0; wd = 1; end
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      while (!s_axi_bvalid && m < 20) begin tick(); m++; end
      lat = (awd && wd && s_axi_bvalid) ? n + m : 99;
      pulse = wr_pulse;
      resp = s_axi_bresp;
      tick();
   endtask

   task automatic axi_read(input logic [3:0] a, output int lat,
                           output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      int m = 0;
      bit done = 0, aa;
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      while (!done && n < 20) begin
         aa = s_axi_arready;
         tick(); n++;
         if (aa) done = 1;
      end
      s_axi_arvalid = 1'b0;
      while (!s_axi_rvalid && m < 20) begin tick(); m++; end
      lat = (done && s_axi_rvalid) ? n + m : 99;
      d = s_axi_rdata;
      resp = s_axi_rresp;
      tick();
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin n_fail++;
         $display("FAIL reset_ready: got %b expected 000", {s_axi_awready, s_axi_wready, s_axi_arready}); end
      n_cmp++; if ({s_axi_bvalid, s_axi_rvalid, wr_pulse} !== 6'd0) begin n_fail++;
         $display("FAIL reset_valid: got %b expected 000000", {s_axi_bvalid, s_axi_rvalid, wr_pulse}); end
      n_cmp++; if ({reg0, reg1, reg2, reg3, s_axi_rdata} !== 160'd0) begin n_fail++;
         $display("FAIL reset_regs: got %h %h %h %h rdata %h expected all 0", reg0, reg1, reg2, reg3, s_axi_rdata); end
      tick(); tick();
      ARESETN = 1'b1;
      #1;
      n_cmp++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin n_fail++;
         $display("FAIL post_reset_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_d [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
      logic [3:0]  a;
      logic [3:0]  pulse;
      logic [1:0]  resp;
      logic [31:0] d;
      logic [3:0]  exp_p;
      int lat;
      for (int i = 0; i < 4; i++) begin
         a = 4'(i * 4);
         exp_p = 4'b0001 << i;
         axi_write(a, exp_d[i], 4'hF, lat, pulse, resp);
         n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL wr_latency[%0d]: got %0d expected 1", i, lat); end
         n_cmp++; if (pulse !== exp_p) begin n_fail++; $display("FAIL wr_pulse[%0d]: got %b expected %b", i, pulse, exp_p); end
         n_cmp++; if (resp !== 2'b00) begin n_fail++; $display("FAIL bresp[%0d]: got %b expected 00", i, resp); end
      end
      n_cmp++; if ({reg0, reg1, reg2, reg3} !== {32'h1, 32'h2, 32'h3, 32'h4}) begin n_fail++;
         $display("FAIL regs_out: got %h %h %h %h expected 1 2 3 4", reg0, reg1, reg2, reg3); end
      for (int i = 0; i < 4; i++) begin
         a = 4'(i * 4) | 4'(i & 1);
         axi_read(a, lat, d, resp);
         n_cmp++; if (d !== exp_d[i]) begin n_fail++; $display("FAIL rdata[%0d]: got %h expected %h", i, d, exp_d[i]); end
         n_cmp++; if (lat !== 1 || resp !== 2'b00) begin n_fail++; $display("FAIL rd_lat_resp[%0d]: got %0d/%b expected 1/00", i, lat, resp); end
      end
   endtask

   task automatic test_w_first();
      s_axi_bready = 1'b1;
      s_axi_wdata = 32'hA5A5A5A5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0;
      n_cmp++; if ({s_axi_bvalid, s_axi_wready} !== 2'b00) begin n_fail++;
         $display("FAIL w_held: bvalid/wready got %b expected 00", {s_axi_bvalid, s_axi_wready}); end
      tick(); tick();
      n_cmp++; if (s_axi_bvalid !== 1'b0 || reg2 !== 32'h3) begin n_fail++;
         $display("FAIL w_wait: bvalid %b reg2 %h expected 0 / 00000003", s_axi_bvalid, reg2); end
      s_axi_awaddr = 4'h8; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      n_cmp++; if ({s_axi_bvalid, wr_pulse} !== 5'b10100 || reg2 !== 32'hA5A5A5A5) begin n_fail++;
         $display("FAIL w_first_commit: bvalid %b pulse %b reg2 %h expected 1 0100 a5a5a5a5", s_axi_bvalid, wr_pulse, reg2); end
      tick();
      n_cmp++; if ({s_axi_bvalid, wr_pulse} !== 5'b00000) begin n_fail++;
         $display("FAIL w_first_after: bvalid %b pulse %b expected 0 0000", s_axi_bvalid, wr_pulse); end
   endtask

   task automatic test_strobe();
      logic [3:0] pulse;
      logic [1:0] resp;
      int lat;
      axi_write(4'h4, 32'h11223344, 4'hF, lat, pulse, resp);
      axi_write(4'h4, 32'hFFFFFFFF, 4'b0101, lat, pulse, resp);
      n_cmp++; if (reg1 !== 32'h11FF33FF) begin n_fail++; $display("FAIL strobe: reg1 got %h expected 11ff33ff", reg1); end
      axi_write(4'h4, 32'h00000000, 4'b0000, lat, pulse, resp);
      n_cmp++; if (pulse !== 4'b0010 || reg1 !== 32'h11FF33FF) begin n_fail++;
         $display("FAIL strobe_zero: pulse %b reg1 %h expected 0010 11ff33ff", pulse, reg1); end
   endtask

   task automatic test_bstall();
      int bad = 0;
      s_axi_bready = 1'b0;
      s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wdata = 32'h66;
      n_cmp++; if (s_axi_bvalid !== 1'b1 || reg0 !== 32'h55) begin n_fail++;
         $display("FAIL bstall_first: bvalid %b reg0 %h expected 1 00000055", s_axi_bvalid, reg0); end
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100 || reg0 !== 32'h55) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bstall_hold: got %0d bad cycles expected 0", bad); end
      s_axi_bready = 1'b1;
      tick();
      n_cmp++; if (s_axi_bvalid !== 1'b0 || reg0 !== 32'h55 || s_axi_awready !== 1'b1) begin n_fail++;
         $display("FAIL bstall_release: bvalid %b awready %b reg0 %h expected 0 1 00000055", s_axi_bvalid, s_axi_awready, reg0); end
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      n_cmp++; if (s_axi_bvalid !== 1'b1 || reg0 !== 32'h66) begin n_fail++;
         $display("FAIL bstall_second: bvalid %b reg0 %h expected 1 00000066", s_axi_bvalid, reg0); end
      tick();
   endtask

   task automatic test_read_stall();
      logic [3:0] pulse;
      logic [1:0] resp;
      int lat;
      int bad = 0;
      axi_write(4'hC, 32'hDEADBEEF, 4'hF, lat, pulse, resp);
      s_axi_rready = 1'b0;
      s_axi_araddr = 4'hC; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hDEADBEEF) bad++;
         tick();
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rstall_hold: got %0d bad cycles expected 0", bad); end
      s_axi_rready = 1'b1;
      tick();
      n_cmp++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstall_release: rvalid got %b expected 0", s_axi_rvalid); end
      s_axi_bready = 1'b1;
      s_axi_awaddr = 4'hC; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'h01234567; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      s_axi_araddr = 4'hC; s_axi_arvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      n_cmp++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hDEADBEEF || reg3 !== 32'h01234567) begin n_fail++;
         $display("FAIL rw_collide: rvalid %b rdata %h reg3 %h expected 1 deadbeef 01234567", s_axi_rvalid, s_axi_rdata, reg3); end
      tick();
   endtask

   task automatic test_back_to_back();
      int nb = 0;
      int nr = 0;
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      s_axi_awaddr = 4'h4; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hCAFE0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s_axi_bvalid) nb++;
         if (s_axi_rvalid) nr++;
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      n_cmp++; if (nb !== 5 || nr !== 5) begin n_fail++;
         $display("FAIL back_to_back: got %0d writes %0d reads expected 5 5", nb, nr); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [3:0]  pulse;
      logic [1:0]  resp;
      logic [31:0] d;
      int lat;
      int bad = 0;
      s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0;
      ARESETN = 1'b0;
      #1;
      n_cmp++; if ({reg0, reg1, reg2, reg3, s_axi_rdata} !== 160'd0 ||
                   {s_axi_bvalid, s_axi_rvalid, wr_pulse, s_axi_awready, s_axi_wready, s_axi_arready} !== 9'd0) begin n_fail++;
         $display("FAIL mid_reset_clear: regs %h %h %h %h rdata %h ctl %b expected all 0", reg0, reg1, reg2, reg3,
                  s_axi_rdata, {s_axi_bvalid, s_axi_rvalid, wr_pulse, s_axi_awready, s_axi_wready, s_axi_arready}); end
      tick();
      ARESETN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (s_axi_bvalid !== 1'b0 || reg0 !== 32'h0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mid_reset_nobresp: got %0d bad cycles expected 0", bad); end
      axi_write(4'h0, 32'h00000077, 4'hF, lat, pulse, resp);
      axi_read(4'h0, lat, d, resp);
      n_cmp++; if (d !== 32'h77 || reg0 !== 32'h77) begin n_fail++;
         $display("FAIL mid_reset_after: rdata %h reg0 %h expected 00000077", d, reg0); end
   endtask

   initial begin
      ARESETN = 1'b0;
      s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      test_reset();
      tick();
      test_basic();
      test_w_first();
      test_strobe();
      test_bstall();
      test_read_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
